// File: rtl/ccx_ic_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ccx_ic_mem_arbiter_if
//
// One core memory-bus link: a request channel (req plus request fields,
// accepted on req & gnt) and a response channel (rdata and err, valid in the
// cycle after acceptance).
//
// Modports:
//   master : the side that issues requests. It drives req/rtype/addr/wen/
//            strb/wdata and receives gnt/err/rdata.
//   slave  : the side that accepts requests. It receives the request fields
//            and drives gnt/err/rdata.
// ---------------------------------------------------------------------------
interface ccx_ic_mem_arbiter_if #(
    parameter int AW = 39,
    parameter int DW = 64
);
    logic              req;
    logic              rtype;
    logic [AW-1:0]     addr;
    logic              wen;
    logic [DW/8-1:0]   strb;
    logic [DW-1:0]     wdata;
    logic              gnt;
    logic              err;
    logic [DW-1:0]     rdata;

    modport master (
        output req, rtype, addr, wen, strb, wdata,
        input  gnt, err, rdata
    );

    modport slave (
        input  req, rtype, addr, wen, strb, wdata,
        output gnt, err, rdata
    );
endinterface

// File: rtl/ccx_ic_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ccx_ic_mem_arbiter
//
// Shares one memory-bus target between two requesters (typically the core
// instruction-fetch and data-access paths). Arbitration is fixed priority,
// with a starvation counter that forces the low-priority requester through
// after STARVE_LIMIT consecutive waiting cycles. A request forwarded to the
// target but not yet granted is locked to its owner until the target grants
// it. Responses arrive one cycle after acceptance and their error flag is
// routed back to the requester that owned the accepted request.
//
// Ports:
//   g_clk   : clock, all state updates on the rising edge
//   g_reset : synchronous active-high reset
//   s0      : requester 0 bus (slave modport: arbiter accepts requests)
//   s1      : requester 1 bus (slave modport)
//   m       : target bus (master modport: arbiter issues requests)
// ---------------------------------------------------------------------------
module ccx_ic_mem_arbiter #(
    parameter int AW           = 39,
    parameter int DW           = 64,
    parameter int HI_PRIO      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    ccx_ic_mem_arbiter_if.slave   s0,
    ccx_ic_mem_arbiter_if.slave   s1,
    ccx_ic_mem_arbiter_if.master  m
);

    // Counter width is clog2(STARVE_LIMIT+1); kept at least one bit so the
    // disabled configuration still has a legal (constant-zero) register.
    localparam int CW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
    localparam logic          HI_ID   = (HI_PRIO != 0);
    localparam logic          LO_ID   = ~HI_ID;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } lock_state_t;

    lock_state_t    state_q, state_d;
    logic           lock_id_q, lock_id_d;
    logic           rsp_vld_q, rsp_vld_d;
    logic           rsp_id_q, rsp_id_d;
    logic [CW-1:0]  wait_ctr_q, wait_ctr_d;

    logic           sel_vld;
    logic           sel_id;
    logic           starve;
    logic           use_s1;
    logic           mreq_w;
    logic           accept;
    logic           gnt0_w;
    logic           gnt1_w;
    logic           lo_req;
    logic           lo_gnt;

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    assign starve = (STARVE_LIMIT != 0) && (wait_ctr_q == LIMIT_C);

    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        if (state_q == HELD) begin
            // A locked request keeps the bus even if the owner drops req.
            sel_vld = 1'b1;
            sel_id  = lock_id_q;
        end else if (s0.req && s1.req) begin
            sel_vld = 1'b1;
            sel_id  = starve ? LO_ID : HI_ID;
        end else if (s0.req || s1.req) begin
            sel_vld = 1'b1;
            sel_id  = s1.req;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding to the target
    // ------------------------------------------------------------------
    // m_req depends only on registers and requester inputs, never on m.gnt.
    assign mreq_w = sel_vld & (sel_id ? s1.req : s0.req) & ~g_reset;
    assign use_s1 = sel_vld & sel_id;
    assign accept = mreq_w & m.gnt;

    assign m.req   = mreq_w;
    assign m.rtype = use_s1 ? s1.rtype : s0.rtype;
    assign m.addr  = use_s1 ? s1.addr  : s0.addr;
    assign m.wen   = use_s1 ? s1.wen   : s0.wen;
    assign m.strb  = use_s1 ? s1.strb  : s0.strb;
    assign m.wdata = use_s1 ? s1.wdata : s0.wdata;

    assign gnt0_w = accept & ~sel_id;
    assign gnt1_w = accept &  sel_id;
    assign s0.gnt = gnt0_w;
    assign s1.gnt = gnt1_w;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // Read data is broadcast; only the error flag needs an owner. The error
    // uses the registered owner, so a new acceptance in the same cycle does
    // not disturb routing of the response that is returning now.
    assign s0.rdata = m.rdata;
    assign s1.rdata = m.rdata;
    assign s0.err   = m.err & rsp_vld_q & ~rsp_id_q & ~g_reset;
    assign s1.err   = m.err & rsp_vld_q &  rsp_id_q & ~g_reset;

    assign rsp_vld_d = accept;
    assign rsp_id_d  = accept ? sel_id : rsp_id_q;

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            IDLE: begin
                if (mreq_w && !m.gnt) begin
                    state_d   = HELD;
                    lock_id_d = sel_id;
                end
            end
            HELD: begin
                if (m.gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    // Counts every cycle the low-priority requester waits, including cycles
    // spent behind a lock or behind a target that is not granting.
    assign lo_req = LO_ID ? s1.req : s0.req;
    assign lo_gnt = LO_ID ? gnt1_w : gnt0_w;

    always_comb begin
        wait_ctr_d = wait_ctr_q;
        if (STARVE_LIMIT == 0) begin
            wait_ctr_d = '0;
        end else if (!lo_req || lo_gnt) begin
            wait_ctr_d = '0;
        end else if (wait_ctr_q != LIMIT_C) begin
            wait_ctr_d = wait_ctr_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q    <= IDLE;
            rsp_vld_q  <= 1'b0;
            wait_ctr_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_vld_q  <= rsp_vld_d;
            wait_ctr_q <= wait_ctr_d;
        end
    end

    // Owner tags are only meaningful while their valid/state bit is set,
    // so they carry no reset.
    always_ff @(posedge g_clk) begin
        lock_id_q <= lock_id_d;
        rsp_id_q  <= rsp_id_d;
    end

endmodule

// File: tb/tb_ccx_ic_mem_arbiter.sv
module tb_ccx_ic_mem_arbiter;

    localparam int AW = 39;
    localparam int DW = 64;

    localparam logic [AW-1:0] A0 = 39'h10000;
    localparam logic [AW-1:0] A1 = 39'h20000;
    localparam logic [DW-1:0] WD1 = 64'h1111_2222_3333_4444;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic g_reset;
    logic c_reset;

    ccx_ic_mem_arbiter_if #(.AW(AW), .DW(DW)) s0_if ();
    ccx_ic_mem_arbiter_if #(.AW(AW), .DW(DW)) s1_if ();
    ccx_ic_mem_arbiter_if #(.AW(AW), .DW(DW)) m_if ();

    ccx_ic_mem_arbiter_if #(.AW(AW), .DW(DW)) c0_if ();
    ccx_ic_mem_arbiter_if #(.AW(AW), .DW(DW)) c1_if ();
    ccx_ic_mem_arbiter_if #(.AW(AW), .DW(DW)) cm_if ();

    ccx_ic_mem_arbiter #(.AW(AW), .DW(DW), .HI_PRIO(1), .STARVE_LIMIT(4)) u_dut (
        .g_clk   (clk),
        .g_reset (g_reset),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if)
    );

    ccx_ic_mem_arbiter #(.AW(AW), .DW(DW), .HI_PRIO(1), .STARVE_LIMIT(0)) u_dut_nostarve (
        .g_clk   (clk),
        .g_reset (c_reset),
        .s0      (c0_if),
        .s1      (c1_if),
        .m       (cm_if)
    );

    typedef struct {
        bit            rst, r0, r1, mg, me;
        logic [DW-1:0] rd;
        bit            xmreq, xg0, xg1, xe0, xe1;
        logic [AW-1:0] xaddr;
        string         nm;
    } vec_t;

    vec_t vq[$];
    bit   sb[$];   // owner id of each accepted request, response due next cycle

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rst, r0, r1, mg, me, input logic [DW-1:0] rd,
                       input bit xmreq, xg0, xg1, xe0, xe1,
                       input logic [AW-1:0] xaddr, input string nm);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.mg = mg; v.me = me; v.rd = rd;
        v.xmreq = xmreq; v.xg0 = xg0; v.xg1 = xg1; v.xe0 = xe0; v.xe1 = xe1;
        v.xaddr = xaddr; v.nm = nm;
        vq.push_back(v);
    endtask

    // One cycle on the main DUT: drive, compare mid-cycle, score responses.
    task automatic step(input vec_t v);
        bit  id;
        bit  is1;
        g_reset     = v.rst;
        s0_if.req   = v.r0;
        s1_if.req   = v.r1;
        m_if.gnt    = v.mg;
        m_if.err    = v.me;
        m_if.rdata  = v.rd;
        @(negedge clk);
        is1 = (v.xaddr == A1);
        check({v.nm, "/mreq"},  64'(m_if.req),   64'(v.xmreq));
        check({v.nm, "/maddr"}, 64'(m_if.addr),  64'(v.xaddr));
        check({v.nm, "/mwen"},  64'(m_if.wen),   64'(is1));
        check({v.nm, "/mrtype"},64'(m_if.rtype), 64'(is1));
        check({v.nm, "/mstrb"}, 64'(m_if.strb),  is1 ? 64'hFF : 64'h0);
        check({v.nm, "/mwdata"},64'(m_if.wdata), is1 ? WD1 : 64'h0);
        check({v.nm, "/gnt0"},  64'(s0_if.gnt),  64'(v.xg0));
        check({v.nm, "/gnt1"},  64'(s1_if.gnt),  64'(v.xg1));
        check({v.nm, "/err0"},  64'(s0_if.err),  64'(v.xe0));
        check({v.nm, "/err1"},  64'(s1_if.err),  64'(v.xe1));
        if (v.rst) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            id = sb.pop_front();
            if (id) begin
                check({v.nm, "/sb_rdata1"}, s1_if.rdata, v.rd);
                check({v.nm, "/sb_err1"},   64'(s1_if.err), 64'(v.me));
            end else begin
                check({v.nm, "/sb_rdata0"}, s0_if.rdata, v.rd);
                check({v.nm, "/sb_err0"},   64'(s0_if.err), 64'(v.me));
            end
        end
        if (!v.rst && (v.xg0 || v.xg1)) sb.push_back(v.xg1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   ctr;
        bit   w;
        vec_t v;

        // Static request fields: s0 is a read, s1 a full-strobe write.
        s0_if.rtype = 1'b0; s0_if.addr = A0; s0_if.wen = 1'b0;
        s0_if.strb  = '0;   s0_if.wdata = '0; s0_if.req = 1'b0;
        s1_if.rtype = 1'b1; s1_if.addr = A1; s1_if.wen = 1'b1;
        s1_if.strb  = 8'hFF; s1_if.wdata = WD1; s1_if.req = 1'b0;
        m_if.gnt = 1'b0; m_if.err = 1'b0; m_if.rdata = '0;

        c0_if.rtype = 1'b0; c0_if.addr = A0; c0_if.wen = 1'b0;
        c0_if.strb  = '0;   c0_if.wdata = '0; c0_if.req = 1'b1;
        c1_if.rtype = 1'b1; c1_if.addr = A1; c1_if.wen = 1'b1;
        c1_if.strb  = 8'hFF; c1_if.wdata = WD1; c1_if.req = 1'b1;
        cm_if.gnt = 1'b1; cm_if.err = 1'b0; cm_if.rdata = '0;

        g_reset = 1'b1;
        c_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //   rst r0 r1 mg me rd                 mreq g0 g1 e0 e1 addr
        add(1, 1, 1, 1, 1, 64'h0,               0, 0, 0, 0, 0, A1, "rst_both");
        add(1, 0, 0, 1, 1, 64'h0,               0, 0, 0, 0, 0, A0, "rst_idle");
        add(0, 1, 0, 1, 0, 64'h0,               1, 1, 0, 0, 0, A0, "single_s0");
        add(0, 0, 0, 1, 0, 64'hDEADBEEF,        0, 0, 0, 0, 0, A0, "single_rsp");
        add(0, 1, 0, 0, 0, 64'h0,               1, 0, 0, 0, 0, A0, "lock_c1");
        add(0, 1, 1, 0, 0, 64'h0,               1, 0, 0, 0, 0, A0, "lock_c2");
        add(0, 1, 1, 0, 0, 64'h0,               1, 0, 0, 0, 0, A0, "lock_c3");
        add(0, 1, 1, 1, 0, 64'h0,               1, 1, 0, 0, 0, A0, "lock_gnt");
        add(0, 0, 1, 1, 0, 64'hCAFE0001,        1, 0, 1, 0, 0, A1, "after_lock_s1");
        add(0, 1, 0, 1, 1, 64'hCAFE0002,        1, 1, 0, 0, 1, A0, "err_to_s1");
        add(0, 0, 0, 1, 0, 64'hCAFE0003,        0, 0, 0, 0, 0, A0, "noerr_s0");
        add(0, 0, 0, 0, 1, 64'h0,               0, 0, 0, 0, 0, A0, "err_no_rsp");
        add(0, 1, 0, 0, 0, 64'h0,               1, 0, 0, 0, 0, A0, "viol_lock");
        add(0, 0, 1, 0, 0, 64'h0,               0, 0, 0, 0, 0, A0, "viol_drop");
        add(0, 0, 1, 1, 0, 64'h0,               0, 0, 0, 0, 0, A0, "viol_release");
        add(0, 0, 1, 1, 0, 64'h0,               1, 0, 1, 0, 0, A1, "viol_next_s1");
        add(0, 0, 0, 0, 0, 64'h55AA,            0, 0, 0, 0, 0, A0, "viol_rsp");

        for (int i = 0; i < vq.size(); i++) step(vq[i]);

        // Contention: expect 4 s1 grants then 1 s0 grant, repeating.
        ctr = 0;
        for (int i = 0; i < 15; i++) begin
            w = (ctr == 4) ? 1'b0 : 1'b1;
            v.rst = 0; v.r0 = 1; v.r1 = 1; v.mg = 1; v.me = 0;
            v.rd = 64'(i) + 64'h100;
            v.xmreq = 1; v.xg0 = ~w; v.xg1 = w; v.xe0 = 0; v.xe1 = 0;
            v.xaddr = w ? A1 : A0;
            v.nm = $sformatf("cont%0d", i);
            step(v);
            ctr = (!w) ? 0 : ((ctr < 4) ? ctr + 1 : 4);
        end
        v.rst = 0; v.r0 = 0; v.r1 = 0; v.mg = 0; v.me = 0; v.rd = 64'h77;
        v.xmreq = 0; v.xg0 = 0; v.xg1 = 0; v.xe0 = 0; v.xe1 = 0; v.xaddr = A0;
        v.nm = "cont_drain";
        step(v);

        // Reset while locked, then reset with a response pending.
        vq.delete();
        add(0, 1, 0, 0, 0, 64'h0,               1, 0, 0, 0, 0, A0, "rl_lock");
        add(1, 1, 1, 1, 1, 64'h0,               0, 0, 0, 0, 0, A0, "rl_reset");
        add(0, 1, 1, 1, 0, 64'h0,               1, 0, 1, 0, 0, A1, "rl_s1_wins");
        add(1, 0, 0, 1, 1, 64'h0,               0, 0, 0, 0, 0, A0, "rl_rsp_drop");
        add(0, 0, 0, 0, 1, 64'h0,               0, 0, 0, 0, 0, A0, "rl_rsp_gone");
        for (int i = 0; i < vq.size(); i++) step(vq[i]);

        // Pure fixed priority instance: s1 wins every cycle.
        c_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("nostarve%0d/gnt1", i), 64'(c1_if.gnt), 64'h1);
            check($sformatf("nostarve%0d/gnt0", i), 64'(c0_if.gnt), 64'h0);
            check($sformatf("nostarve%0d/addr", i), 64'(cm_if.addr), 64'(A1));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccx_ic_mem_arbiter.md
Name: ccx_ic_mem_arbiter

Overview:
- Two-requester arbiter that shares one core memory-bus target between two masters. Typical use: the single-ported RAM, or the external port, shared by the core instruction fetch and data access paths.
- Sits inside the core-complex interconnect, between the core imem/dmem request buses and one target bus.
- Fixed priority with a starvation counter, request locking until grant, and routing of one-cycle-delayed responses.

Parameters:
- AW, 39, address width.
- DW, 64, data width; strobe width is DW/8.
- HI_PRIO, 1, index of the high-priority requester (0 or 1).
- STARVE_LIMIT, 4, consecutive waiting cycles after which the low-priority requester is forced to win; 0 disables this (pure fixed priority).

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  reset.
- s0_req  in  1  requester 0 request.
- s0_rtype  in  1  requester 0 request type.
- s0_addr  in  AW  requester 0 address.
- s0_wen  in  1  requester 0 write enable.
- s0_strb  in  DW/8  requester 0 write strobe.
- s0_wdata  in  DW  requester 0 write data.
- s0_gnt  out  1  requester 0 request accepted.
- s0_err  out  1  requester 0 response error.
- s0_rdata  out  DW  requester 0 read data.
- s1_*  same set as s0_*, for requester 1.
- m_req, m_rtype, m_addr, m_wen, m_strb, m_wdata  out  1/1/AW/1/DW/8/DW  target request.
- m_gnt  in  1  target accepted the request.
- m_err  in  1  target response error.
- m_rdata  in  DW  target response read data.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is g_clk, reset port is g_reset; all state is updated on the rising edge of g_clk.
- Protocol:
  - A request is accepted in the cycle where req&gnt is high.
  - The requester holds req and all request fields stable until gnt.
  - The response (rdata, err) arrives from the target in the cycle after acceptance.
- State registers:
  - lock_vld, lock_id: forwarded request not yet granted, and its owner.
  - rsp_vld, rsp_id: response due this cycle, and its owner.
  - wait_ctr: starvation counter, width clog2(STARVE_LIMIT+1).
- Selection (combinational from the registers and the current req inputs):
  - If lock_vld: sel = lock_id.
  - Else if only one requester has req high: sel = that requester.
  - Else if both have req high: sel = low-priority requester if STARVE_LIMIT!=0 and wait_ctr==STARVE_LIMIT, otherwise the HI_PRIO requester.
  - Else: no selection, m_req=0.
- Forwarding:
  - m_req = sel's req.
  - m_rtype/addr/wen/strb/wdata mux from sel; they are driven from requester 0 when there is no selection.
  - sK_gnt = m_gnt & m_req & (sel==K); the unselected requester sees gnt=0.
  - There is no combinational path from m_gnt to m_req.
- Lock FSM (two states, IDLE and HELD):
  - IDLE->HELD when m_req & !m_gnt; lock_id = sel.
  - HELD->IDLE when m_gnt.
  - In HELD, the other requester cannot preempt even if it has higher priority.
- Responses:
  - On m_req&m_gnt: rsp_vld<=1 and rsp_id<=sel. Otherwise rsp_vld<=0.
  - m_rdata is broadcast to both sK_rdata unchanged.
  - sK_err = m_err & rsp_vld & (rsp_id==K).
- Back-to-back operation: accepting a new request in the same cycle a response returns is legal. rsp_id then updates to the new owner, and the current-cycle err routing uses the old rsp_id.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the low-priority requester has req=1 and gnt=0.
  - Clears to 0 when the low-priority requester is granted, or when its req=0.
  - Held at 0 when STARVE_LIMIT=0.
- Reset:
  - While g_reset=1: lock_vld=0, rsp_vld=0, wait_ctr=0.
  - While g_reset=1, outputs are forced: m_req=0, s0_gnt=s1_gnt=0, s0_err=s1_err=0.
  - A reset mid-transaction drops the lock, and any pending response is discarded (err is not routed).
- Boundary cases:
  - Requester deasserting req while locked is a protocol violation. Lock still releases only on m_gnt, and m_req follows the locked requester's req.
  - m_err while rsp_vld=0 is ignored.
- Target: 120-200 lines of RTL.

Test Plan:
- Single requester: s0 read addr 0x10000, m_gnt=1 -> same cycle m_addr=0x10000, s0_gnt=1; next cycle m_rdata=0xDEADBEEF reaches s0_rdata, s0_err=0, s1_err=0.
- Contention, HI_PRIO=1, STARVE_LIMIT=4, m_gnt=1 every cycle, both requesting continuously -> s1 granted 4 cycles; 5th cycle s0 granted, wait_ctr back to 0; pattern repeats (4:1).
- Lock: s0 alone requests with m_gnt=0 for 3 cycles, s1 raises req in cycle 2 -> m_addr stays s0's address; on m_gnt s0_gnt=1; s1 granted in the following cycle.
- Error routing: s1 write granted (strb=0xFF) and s0 read granted the next cycle; m_err=1 in the cycle after s1's grant -> s1_err=1, s0_err=0; m_err=0 next cycle -> s0_err=0.
- Reset mid-lock: s0 locked with m_gnt=0, assert g_reset for 1 cycle -> m_req=0, all gnt/err=0 that cycle; after release with both requesting, s1 wins (counter cleared).
- STARVE_LIMIT=0, both requesting for 20 cycles -> s1 granted every cycle, s0_gnt never asserted.
